// File: rtl/rx_mac_hash_calc_if.sv
// Lookup request channel from the RX MAC hash stage to the MAC table.
// Valid/ready handshake; the payload is held stable while valid is high and not accepted.
interface rx_mac_hash_calc_if #(
  parameter int PORT_NUM   = 8,
  parameter int HASH_WIDTH = 12
);
  logic                  o_lkup_vld;
  logic                  i_lkup_ready;
  logic [47:0]           o_lkup_dmac;
  logic [47:0]           o_lkup_smac;
  logic [HASH_WIDTH-1:0] o_lkup_dmac_hash;
  logic [HASH_WIDTH-1:0] o_lkup_smac_hash;
  logic [PORT_NUM-1:0]   o_lkup_rx_port;
  logic [11:0]           o_lkup_vlan_id;

  modport master (
    output o_lkup_vld, o_lkup_dmac, o_lkup_smac, o_lkup_dmac_hash, o_lkup_smac_hash,
           o_lkup_rx_port, o_lkup_vlan_id,
    input  i_lkup_ready
  );

  modport slave (
    input  o_lkup_vld, o_lkup_dmac, o_lkup_smac, o_lkup_dmac_hash, o_lkup_smac_hash,
           o_lkup_rx_port, o_lkup_vlan_id,
    output i_lkup_ready
  );
endinterface

// File: rtl/rx_mac_hash_calc.sv
// RX MAC address assembly and hash: collects DMAC/SMAC byte streams, folds each into a
// hash index, pairs them per frame and issues one MAC-table lookup request per frame.
module rx_mac_collector #(
  parameter int HASH_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_data,
  input  logic                  i_vld,
  input  logic                  i_soc,
  input  logic                  i_eoc,
  output logic                  o_done,
  output logic                  o_err,
  output logic [47:0]           o_mac,
  output logic [HASH_WIDTH-1:0] o_hash
);
  typedef enum logic {IDLE, COLLECT} state_e;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [39:0] shift_q;
  logic [15:0] acc_q;

  logic        active;
  logic [2:0]  idx;
  logic [15:0] acc_nxt;

  // Even byte indices land in the high half of a 16-bit word, odd ones in the low half,
  // so the three-word XOR is built one byte at a time.
  always_comb begin
    active  = i_soc || (state_q == COLLECT);
    idx     = i_soc ? 3'd0 : idx_q;
    acc_nxt = (i_soc ? 16'h0 : acc_q) ^ (idx[0] ? {8'h00, i_data} : {i_data, 8'h00});
    o_mac   = {shift_q, i_data};
    o_done  = i_vld && !i_soc && (state_q == COLLECT) && i_eoc && (idx_q == 3'd5);
    o_err   = i_vld && ((i_soc && state_q == COLLECT) ||
                        (!i_soc && state_q == IDLE) ||
                        (active && i_eoc && idx != 3'd5) ||
                        (active && !i_eoc && idx == 3'd5));
  end

  if (HASH_WIDTH == 16) begin : g_nofold
    assign o_hash = acc_nxt;
  end else begin : g_fold
    assign o_hash = acc_nxt[HASH_WIDTH-1:0] ^ HASH_WIDTH'(acc_nxt >> HASH_WIDTH);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
    end else if (i_vld && active) begin
      if (i_eoc || idx == 3'd5) begin
        state_q <= IDLE;
      end else begin
        state_q <= COLLECT;
        idx_q   <= idx + 3'd1;
        shift_q <= {shift_q[31:0], i_data};
        acc_q   <= acc_nxt;
      end
    end
  end
endmodule

module rx_mac_hash_calc #(
  parameter int PORT_NUM   = 8,
  parameter int HASH_WIDTH = 12
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_dmac_data,
  input  logic                i_dmac_vld,
  input  logic                i_dmac_soc,
  input  logic                i_dmac_eoc,
  input  logic [7:0]          i_smac_data,
  input  logic                i_smac_vld,
  input  logic                i_smac_soc,
  input  logic                i_smac_eoc,
  input  logic [PORT_NUM-1:0] i_rx_port,
  input  logic [11:0]         i_vlan_id,
  rx_mac_hash_calc_if.master  lkup,
  output logic                o_mac_err,
  output logic                o_lkup_drop,
  output logic [15:0]         o_drop_cnt
);
  localparam int LN_D = 0;
  localparam int LN_S = 1;

  typedef struct packed {
    logic [47:0]           dmac;
    logic [47:0]           smac;
    logic [HASH_WIDTH-1:0] dmac_hash;
    logic [HASH_WIDTH-1:0] smac_hash;
    logic [PORT_NUM-1:0]   rx_port;
    logic [11:0]           vlan_id;
  } req_t;

  logic [1:0][7:0]            c_data;
  logic [1:0]                 c_vld, c_soc, c_eoc, c_done, c_err;
  logic [1:0][47:0]           c_mac;
  logic [1:0][HASH_WIDTH-1:0] c_hash;

  assign c_data = {i_smac_data, i_dmac_data};
  assign c_vld  = {i_smac_vld, i_dmac_vld};
  assign c_soc  = {i_smac_soc, i_dmac_soc};
  assign c_eoc  = {i_smac_eoc, i_dmac_eoc};

  for (genvar g = 0; g < 2; g++) begin : g_col
    rx_mac_collector #(.HASH_WIDTH(HASH_WIDTH)) u_col (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_data (c_data[g]),
      .i_vld  (c_vld[g]),
      .i_soc  (c_soc[g]),
      .i_eoc  (c_eoc[g]),
      .o_done (c_done[g]),
      .o_err  (c_err[g]),
      .o_mac  (c_mac[g]),
      .o_hash (c_hash[g])
    );
  end

  logic                  held_q, held_d;
  logic [47:0]           held_mac_q, held_mac_d;
  logic [HASH_WIDTH-1:0] held_hash_q, held_hash_d;
  logic                  req_vld_q, req_vld_d;
  req_t                  req_q, req_d;
  logic                  mac_err_q, mac_err_d;
  logic                  drop_q, drop_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic                  new_req, accept, pair_err;

  // An SMAC completing alongside a DMAC pairs with the DMAC held from before;
  // the new DMAC then takes the held slot without counting as an overwrite.
  always_comb begin
    held_d      = held_q;
    held_mac_d  = held_mac_q;
    held_hash_d = held_hash_q;
    req_vld_d   = req_vld_q;
    req_d       = req_q;
    drop_d      = 1'b0;
    drop_cnt_d  = drop_cnt_q;

    new_req  = c_done[LN_S] && held_q;
    accept   = req_vld_q && lkup.i_lkup_ready;
    pair_err = (c_done[LN_S] && !held_q) || (c_done[LN_D] && held_q && !c_done[LN_S]);

    if (c_done[LN_D]) begin
      held_d      = 1'b1;
      held_mac_d  = c_mac[LN_D];
      held_hash_d = c_hash[LN_D];
    end else if (c_done[LN_S]) begin
      held_d = 1'b0;
    end

    if (new_req && (!req_vld_q || accept)) begin
      req_vld_d = 1'b1;
      req_d     = '{dmac: held_mac_q, smac: c_mac[LN_S], dmac_hash: held_hash_q,
                    smac_hash: c_hash[LN_S], rx_port: i_rx_port, vlan_id: i_vlan_id};
    end else begin
      if (accept) req_vld_d = 1'b0;
      if (new_req) begin
        drop_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end

    mac_err_d = |c_err || pair_err;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      held_q      <= 1'b0;
      held_mac_q  <= '0;
      held_hash_q <= '0;
      req_vld_q   <= 1'b0;
      req_q       <= '0;
      mac_err_q   <= 1'b0;
      drop_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      held_q      <= held_d;
      held_mac_q  <= held_mac_d;
      held_hash_q <= held_hash_d;
      req_vld_q   <= req_vld_d;
      req_q       <= req_d;
      mac_err_q   <= mac_err_d;
      drop_q      <= drop_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign lkup.o_lkup_vld       = req_vld_q;
  assign lkup.o_lkup_dmac      = req_q.dmac;
  assign lkup.o_lkup_smac      = req_q.smac;
  assign lkup.o_lkup_dmac_hash = req_q.dmac_hash;
  assign lkup.o_lkup_smac_hash = req_q.smac_hash;
  assign lkup.o_lkup_rx_port   = req_q.rx_port;
  assign lkup.o_lkup_vlan_id   = req_q.vlan_id;
  assign o_mac_err             = mac_err_q;
  assign o_lkup_drop           = drop_q;
  assign o_drop_cnt            = drop_cnt_q;
endmodule

// File: doc/rx_mac_hash_calc.md
# rx_mac_hash_calc

Per-port receive stage directly downstream of the frame-info extractor. It consumes the destination and source MAC byte streams, each framed by a start (soc) and end (eoc) marker. It assembles both 48-bit addresses, computes a folded XOR hash for each, pairs them per frame with the ingress port bitmap and VLAN ID, and issues one lookup request per frame to the MAC table over a valid/ready handshake.

## Interface
Parameters:
- PORT_NUM, 8, switch port count; sets the width of the rx_port bitmap.
- HASH_WIDTH, 12, width of the hash index. Legal range is 8..16.

Ports:
- i_clk  in  1  single clock; all logic on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_dmac_data  in  8  DMAC byte; first byte is MAC[47:40]
- i_dmac_vld  in  1  DMAC byte valid
- i_dmac_soc  in  1  first DMAC byte (qualified by vld)
- i_dmac_eoc  in  1  last DMAC byte (qualified by vld)
- i_smac_data / i_smac_vld / i_smac_soc / i_smac_eoc  in  8/1/1/1  same as the DMAC inputs, for the SMAC
- i_rx_port  in  PORT_NUM  ingress port bitmap; sampled on the SMAC completion cycle
- i_vlan_id  in  12  VLAN ID; sampled on the SMAC completion cycle
- o_lkup_vld  out  1  lookup request valid
- i_lkup_ready  in  1  MAC table accepts the request
- o_lkup_dmac, o_lkup_smac  out  48  assembled addresses
- o_lkup_dmac_hash, o_lkup_smac_hash  out  HASH_WIDTH  hash indices
- o_lkup_rx_port  out  PORT_NUM; o_lkup_vlan_id  out  12
- o_mac_err  out  1  one-cycle pulse on any framing or pairing error
- o_lkup_drop  out  1  one-cycle pulse when a request is dropped
- o_drop_cnt  out  16  count of dropped requests; saturates at 0xFFFF

## Operation
- There are two identical collector FSMs, one for DMAC and one for SMAC. States are IDLE and COLLECT, with a 3-bit byte index.
  - vld&soc: enter COLLECT with index 0 and store the byte. If already in COLLECT, also pulse o_mac_err (restart).
  - vld without soc in IDLE: ignore the byte and pulse o_mac_err.
  - In COLLECT, each vld byte advances the index.
  - eoc on index 5: good completion; return to IDLE.
  - eoc on index <5 (including soc&eoc on the same byte): pulse o_mac_err, discard, return to IDLE.
  - vld with index 5 but no eoc: pulse o_mac_err, discard, return to IDLE.
- Hash calculation:
  - w0=MAC[47:32], w1=MAC[31:16], w2=MAC[15:0].
  - h16 = w0^w1^w2.
  - hash = h16[HASH_WIDTH-1:0] ^ zero-extended (h16 >> HASH_WIDTH).
  - If HASH_WIDTH=16, hash = h16.
  - The running XOR is accumulated per byte, so no wide combinational path exists at eoc.
- Pairing:
  - A good DMAC completion stores the address and hash and sets dmac_held.
  - A good DMAC completion while dmac_held is set overwrites the stored entry and pulses o_mac_err.
  - A good SMAC completion with dmac_held set builds a request and clears dmac_held.
  - A good SMAC completion with dmac_held clear is discarded and pulses o_mac_err.
  - When DMAC and SMAC complete in the same cycle, the SMAC pairs with the previously held DMAC (if any). The new DMAC is then stored.
- Request register (1 deep):
  - A new request loads the register when it is empty or is being accepted in the same cycle (o_lkup_vld&i_lkup_ready).
  - Otherwise the new request is dropped: o_lkup_drop pulses and o_drop_cnt increments with saturation.
  - A pending request is never overwritten.
- Multiple o_mac_err sources in the same cycle produce a single pulse.

## Timing
- Reset values:
  - All outputs are 0, except that o_lkup_dmac/smac, hashes, rx_port and vlan_id are also cleared to 0.
  - Both collectors go to IDLE; dmac_held and the request register are cleared.
- A reset in mid-collection or mid-handshake abandons all state, with no error or drop pulse.
- Latency: SMAC eoc at cycle M gives o_lkup_vld=1 at M+1. A DMAC eoc at cycle N can pair with an SMAC eoc at cycle ≥N+1.
- Handshake:
  - o_lkup_vld stays high and the payload stays stable until a cycle with i_lkup_ready=1.
  - o_lkup_vld falls the cycle after acceptance unless a new request loads in the acceptance cycle.
  - Throughput is one request per cycle.
- o_mac_err and o_lkup_drop are registered and assert in the cycle after the causing event.

## Test plan
- DMAC FF-FF-FF-FF-FF-FF, then SMAC 00-11-22-33-44-55, with i_rx_port=8'h04, i_vlan_id=12'h00A, i_lkup_ready=1 -> one o_lkup_vld pulse at SMAC eoc+1 with:
  - dmac_hash=12'hFF0, smac_hash=12'h671 (h16=0x6677)
  - rx_port=8'h04, vlan_id=12'h00A
  - no o_mac_err.
- Same frame with i_lkup_ready=0 for 5 cycles, then 1 -> o_lkup_vld held for 6 cycles with the payload stable, then low.
- A second frame completes while the first is still pending with ready=0 -> o_lkup_drop pulses once, o_drop_cnt=1, and the first payload is unchanged.
- DMAC of 5 bytes (eoc at index 4) -> o_mac_err pulse and no request; a following good 6-byte frame is processed normally.
- SMAC with no prior DMAC -> o_mac_err and no request. Then DMAC eoc and SMAC eoc in the same cycle -> no request, and the new DMAC is held and pairs with the next SMAC.
- Assert i_rst for 1 cycle mid-DMAC collection -> all outputs are 0 the next cycle, and a subsequent full frame yields exactly one correct request.
